approx_mult_pipe: RTL and testbench



---
 rtl/approx_mult_pkg.sv | 34 +++
 rtl/approx_col_compress.sv | 60 ++++++
 rtl/approx_mult_pipe.sv | 156 +++++++++++++++
 tb/tb_approx_mult_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// Shared definitions for the pipelined approximate multiplier:
// pipeline latency, the per-transaction mode encoding and a bit-level
// reference model of the approximate product.
package approx_mult_pkg;

  localparam int LATENCY = 3;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_t;

  // Reference product for operands up to 32 bits. Columns below `cols`
  // contribute a single OR bit each; everything above is summed exactly.
  // cols = 0 gives the exact product.
  function automatic logic [63:0] approx_ref(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int          cols);
    logic [63:0] hi;
    logic [63:0] lo;
    hi = '0;
    lo = '0;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        if (a[j] && b[i]) begin
          if (i + j >= cols) hi = hi + (64'd1 << (i + j));
          else               lo[i + j] = 1'b1;
        end
      end
    end
    return hi + lo;
  endfunction

endpackage

// File: rtl/approx_col_compress.sv
// Column compression for the approximate multiplier. Reduces the partial
// product array to two rows whose sum is the (approximate) product.
// In approximate mode the low APPROX_COLS columns are collapsed to one OR
// bit each and placed in row_s; row_c is zero there, so adding the two rows
// never carries out of the low region into the exact region.
module approx_col_compress
  import approx_mult_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int APPROX_COLS = 8
) (
  input  logic [WIDTH-1:0][WIDTH-1:0] pp,
  input  mode_t                       mode,
  output logic [2*WIDTH-1:0]          row_s,
  output logic [2*WIDTH-1:0]          row_c
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] col_mask;
  logic [PW-1:0] or_row;
  logic [PW-1:0] pp_row;
  logic [PW-1:0] sum;
  logic [PW-1:0] carry;
  logic [PW-1:0] nsum;
  logic [PW-1:0] ncarry;

  // OR-compress the low columns and carry-save the rest down to two rows
  always_comb begin
    col_mask = '1;
    or_row   = '0;
    pp_row   = '0;
    sum      = '0;
    carry    = '0;
    nsum     = '0;
    ncarry   = '0;
    if (mode == MODE_APPROX) begin
      for (int c = 0; c < PW; c++) begin
        if (c < APPROX_COLS) col_mask[c] = 1'b0;
      end
      for (int i = 0; i < WIDTH; i++) begin
        for (int j = 0; j < WIDTH; j++) begin
          if (i + j < APPROX_COLS) or_row[i + j] = or_row[i + j] | pp[i][j];
        end
      end
    end
    // Masked rows have no bits in low columns, and carries only move
    // upward, so the CSA output stays clear below APPROX_COLS.
    for (int i = 0; i < WIDTH; i++) begin
      pp_row = (PW'(pp[i]) << i) & col_mask;
      nsum   = sum ^ carry ^ pp_row;
      ncarry = ((sum & carry) | (sum & pp_row) | (carry & pp_row)) << 1;
      sum    = nsum;
      carry  = ncarry;
    end
    row_s = sum | or_row;
    row_c = carry;
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// Three-stage pipelined unsigned WIDTH x WIDTH multiplier with a per-
// transaction exact/approximate mode and valid/ready handshakes.
//   S1: partial-product array, mode, tag
//   S2: two compressed rows, mode, tag
//   S3: carry-propagate sum (output register)
// The stall is global: every stage advances only when the output register
// is empty or being drained.
// Optional: define APPROX_MULT_STATS_EN to add transaction counters.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int APPROX_COLS = 8,
  parameter int TAG_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_mode,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_res,
  output logic                 out_mode,
  output logic [TAG_W-1:0]     out_tag
`ifdef APPROX_MULT_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [31:0]          stat_txn_cnt,
  output logic [31:0]          stat_approx_cnt
`endif
);

  localparam int PW = 2 * WIDTH;

  logic                        advance;
  logic                        accept;
  logic [WIDTH-1:0][WIDTH-1:0] pp_d;
  logic [PW-1:0]               row_s_d;
  logic [PW-1:0]               row_c_d;

  logic                        s1_valid_q;
  logic [WIDTH-1:0][WIDTH-1:0] s1_pp_q;
  mode_t                       s1_mode_q;
  logic [TAG_W-1:0]            s1_tag_q;

  logic                        s2_valid_q;
  logic [PW-1:0]               s2_row_s_q;
  logic [PW-1:0]               s2_row_c_q;
  mode_t                       s2_mode_q;
  logic [TAG_W-1:0]            s2_tag_q;

  logic                        out_valid_q;
  logic [PW-1:0]               out_res_q;
  mode_t                       out_mode_q;
  logic [TAG_W-1:0]            out_tag_q;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance && !flush && rst_n;
  assign accept   = in_valid && in_ready;

  // Partial-product array: pp[i][j] = a[j] & b[i], weight 2^(i+j)
  always_comb begin
    pp_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp_d[i][j] = in_a[j] & in_b[i];
      end
    end
  end

  approx_col_compress #(
    .WIDTH       (WIDTH),
    .APPROX_COLS (APPROX_COLS)
  ) u_compress (
    .pp    (s1_pp_q),
    .mode  (s1_mode_q),
    .row_s (row_s_d),
    .row_c (row_c_d)
  );

  // Stage valid bits: cleared by reset or flush, shifted on advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (advance) begin
      s1_valid_q  <= accept;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
    end
  end

  // Internal data stages load only when holding a live transaction
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_pp_q   <= pp_d;
      s1_mode_q <= mode_t'(in_mode);
      s1_tag_q  <= in_tag;
    end
    if (advance && s1_valid_q) begin
      s2_row_s_q <= row_s_d;
      s2_row_c_q <= row_c_d;
      s2_mode_q  <= s1_mode_q;
      s2_tag_q   <= s1_tag_q;
    end
  end

  // Output register: reset to zero, holds while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_res_q  <= '0;
      out_mode_q <= MODE_EXACT;
      out_tag_q  <= '0;
    end else if (advance && s2_valid_q && !flush) begin
      out_res_q  <= s2_row_s_q + s2_row_c_q;
      out_mode_q <= s2_mode_q;
      out_tag_q  <= s2_tag_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_mode  = out_mode_q;
  assign out_tag   = out_tag_q;

`ifdef APPROX_MULT_STATS_EN
  logic [31:0] stat_txn_q;
  logic [31:0] stat_approx_q;

  // Saturating delivery counters; clear beats increment, flush leaves them
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      stat_txn_q    <= '0;
      stat_approx_q <= '0;
    end else if (out_valid_q && out_ready) begin
      if (stat_txn_q != 32'hFFFF_FFFF) stat_txn_q <= stat_txn_q + 32'd1;
      if (out_mode_q == MODE_APPROX && stat_approx_q != 32'hFFFF_FFFF)
        stat_approx_q <= stat_approx_q + 32'd1;
    end
  end

  assign stat_txn_cnt    = stat_txn_q;
  assign stat_approx_cnt = stat_approx_q;
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe (WIDTH=16, APPROX_COLS=8, TAG_W=4).
// A negedge monitor keeps an in-order scoreboard of accepted pairs and
// checks every delivered result; the main sequence adds directed checks.
module tb_approx_mult_pipe;
  import approx_mult_pkg::*;

  localparam int W    = 16;
  localparam int COLS = 8;
  localparam int TW   = 4;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_a;
  logic [W-1:0]    in_b;
  logic            in_mode;
  logic [TW-1:0]   in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  out_res;
  logic            out_mode;
  logic [TW-1:0]   out_tag;
`ifdef APPROX_MULT_STATS_EN
  logic            stat_clr;
  logic [31:0]     stat_txn_cnt;
  logic [31:0]     stat_approx_cnt;
`endif

  approx_mult_pipe #(
    .WIDTH       (W),
    .APPROX_COLS (COLS),
    .TAG_W       (TW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_mode  (out_mode),
    .out_tag   (out_tag)
`ifdef APPROX_MULT_STATS_EN
    ,
    .stat_clr        (stat_clr),
    .stat_txn_cnt    (stat_txn_cnt),
    .stat_approx_cnt (stat_approx_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [2*W-1:0] res;
    logic           mode;
    logic [TW-1:0]  tag;
  } exp_t;

  exp_t           sb[$];
  logic           prev_stall = 1'b0;
  logic [2*W-1:0] held_res;
  logic           held_mode;
  logic [TW-1:0]  held_tag;

  // Scoreboard monitor: sampled mid-cycle, mirrors the next rising edge
  always @(negedge clk) begin
    exp_t e;
    logic [63:0] r;
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) begin
        check("hold_res", out_res, held_res);
        check("hold_tag", out_tag, held_tag);
        check("hold_mode", out_mode, held_mode);
      end
      if (out_valid && !out_ready) check("in_ready_stall", in_ready, 1'b0);
      if (out_valid && sb.size() == 0) begin
        check("stale_out", out_valid, 1'b0);
      end else if (out_valid && out_ready) begin
        e = sb.pop_front();
        check("sb_res", out_res, e.res);
        check("sb_tag", out_tag, e.tag);
        check("sb_mode", out_mode, e.mode);
        n_out++;
      end
      prev_stall = out_valid && !out_ready;
      held_res   = out_res;
      held_mode  = out_mode;
      held_tag   = out_tag;
      if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        r      = approx_ref(32'(in_a), 32'(in_b), in_mode ? COLS : 0);
        e.res  = r[2*W-1:0];
        e.mode = in_mode;
        e.tag  = in_tag;
        sb.push_back(e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Offer one pair into an empty pipe and check it returns on the third cycle
  task automatic send_and_check(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic m, input logic [TW-1:0] t,
                                input logic [2*W-1:0] exp, input string nm);
    in_a = a; in_b = b; in_mode = m; in_tag = t; in_valid = 1'b1;
    @(negedge clk);
    check({nm, "_acc"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({nm, "_c1"}, out_valid, 1'b0);
    @(posedge clk); #1;
    check({nm, "_c2"}, out_valid, 1'b0);
    @(posedge clk); #1;
    check({nm, "_c3"}, out_valid, 1'b1);
    check({nm, "_res"}, out_res, exp);
    check({nm, "_tag"}, out_tag, t);
  endtask

  task automatic wait_drain(input int target, input string nm);
    for (int k = 0; k < 60 && n_out < target; k++) @(posedge clk);
    #1;
    check(nm, n_out, target);
  endtask

  initial begin
    int sent;
    int cyc;
    int base;
    logic acc;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_mode = 1'b0; in_tag = '0;
`ifdef APPROX_MULT_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_res", out_res, 0);
    check("rst_out_tag", out_tag, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Small operands, both modes
    send_and_check(16'd3, 16'd3, 1'b1, 4'h1, 32'd7, "a3b3_m1");
    @(posedge clk); #1;
    send_and_check(16'd3, 16'd3, 1'b0, 4'h2, 32'd9, "a3b3_m0");
    @(posedge clk); #1;

    // All-ones operands back to back, tags returned in order
    in_a = 16'hFFFF; in_b = 16'hFFFF; in_mode = 1'b0; in_tag = 4'h5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_mode = 1'b1; in_tag = 4'hA;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("ffff_m0_res", out_res, 32'hFFFE_0001);
    check("ffff_m0_tag", out_tag, 4'h5);
    @(posedge clk); #1;
    check("ffff_m1_res", out_res, 32'hFFFD_F9FF);
    check("ffff_m1_tag", out_tag, 4'hA);
    check("ffff_m1_mode", out_mode, 1'b1);
    @(posedge clk); #1;

    // Random stream of 100 pairs with a 4-cycle output stall
    base = n_out; sent = 0; cyc = 0;
    in_a = 16'($urandom); in_b = 16'($urandom);
    in_mode = 1'($urandom_range(0, 1)); in_tag = 4'($urandom);
    while (sent < 100 && cyc < 2000) begin
      in_valid  = 1'b1;
      out_ready = !(cyc >= 30 && cyc < 34);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        in_a = 16'($urandom); in_b = 16'($urandom);
        in_mode = 1'($urandom_range(0, 1)); in_tag = 4'($urandom);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream_sent", sent, 100);
    wait_drain(base + 100, "stream_count");

    // Flush with three pairs in flight
    base = n_out;
    for (int k = 0; k < 3; k++) begin
      in_a = 16'(100 + k); in_b = 16'(7 + k); in_mode = 1'(k); in_tag = 4'(k + 3);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    in_a = 16'd55; in_b = 16'd66; in_tag = 4'hC;
    #1;
    check("flush_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_delivered", n_out, base + 1);
    repeat (5) @(posedge clk);
    #1;
    check("flush_no_stale", n_out, base + 1);
    send_and_check(16'd1234, 16'd5, 1'b0, 4'h9, 32'd6170, "post_flush");
    @(posedge clk); #1;

    // Reset while full and stalled
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_a = 16'(200 + k); in_b = 16'(300 + k); in_mode = 1'b1; in_tag = 4'(k);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("full_out_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_res", out_res, 0);
    check("midrst_out_tag", out_tag, 0);
    check("midrst_out_mode", out_mode, 1'b0);
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    send_and_check(16'h00FF, 16'h0101, 1'b1, 4'h7, 32'h0000_FFFF, "post_rst");
    @(posedge clk); #1;

`ifdef APPROX_MULT_STATS_EN
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    base = n_out;
    for (int k = 0; k < 10; k++) begin
      in_a = 16'(k + 1); in_b = 16'(k + 2); in_mode = (k < 4); in_tag = 4'(k);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_drain(base + 10, "stats_drain");
    check("stat_txn", stat_txn_cnt, 10);
    check("stat_approx", stat_approx_cnt, 4);
    in_a = 16'd9; in_b = 16'd9; in_mode = 1'b1; in_tag = 4'h1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("clr_hs_valid", out_valid, 1'b1);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    check("clr_txn", stat_txn_cnt, 0);
    check("clr_approx", stat_approx_cnt, 0);
`endif

    repeat (LATENCY + 2) @(posedge clk);
    #1;
    check("sb_empty_end", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
